imm_encode: RTL

- Inverse of the RV32I immediate extender: packs a 32-bit immediate into the I/S/B/J bit positions of INSTR[31:7].
- Non-immediate fields come from a caller-supplied template.
- Two-stage valid/ready pipeline with range/alignment checking and a saturating error counter.
- Used by the self-test instruction generator and the assembler-side loader of the RV32I core.

---
 rtl/imm_encode.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/imm_encode.sv
// imm_encode: inverse of the RV32I immediate extender. A 32-bit immediate is
// scattered into the I/S/B/J immediate positions of instruction bits [31:7].
// All other bits come from a caller-supplied template. The datapath is a
// two-stage valid/ready pipeline that also flags immediates the selected
// format cannot represent, and keeps a saturating count of flagged beats.
module imm_encode #(
   parameter int CNTW = 8
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            IN_VALID,
   output logic            IN_READY,
   input  logic [31:0]     IMM,
   input  logic [1:0]      IMMSCR,
   input  logic [24:0]     TEMPLATE,
   output logic            OUT_VALID,
   input  logic            OUT_READY,
   output logic [24:0]     INSTR,
   output logic            ERR,
   output logic [CNTW-1:0] ERRCNT
);

   typedef enum logic [1:0] {
      FMT_I = 2'b00,
      FMT_S = 2'b01,
      FMT_B = 2'b10,
      FMT_J = 2'b11
   } fmt_e;

   // Stage 1: raw beat
   logic            r_s1_valid;
   logic [31:0]     r_s1_imm;
   fmt_e            r_s1_fmt;
   logic [24:0]     r_s1_tmpl;

   // Stage 2: encoded beat
   logic            r_s2_valid;
   logic [24:0]     r_s2_instr;
   logic            r_s2_err;

   logic [CNTW-1:0] r_errcnt;

   logic            w_s1_en;
   logic            w_s2_en;
   logic            w_out_xfer;
   logic [24:0]     w_instr;
   logic            w_err;
   logic            w_fit11;
   logic            w_fit12;
   logic            w_fit20;

   // A stage advances when it is empty or its consumer drains it this cycle.
   assign w_s2_en    = ~r_s2_valid | OUT_READY;
   assign w_s1_en    = ~r_s1_valid | w_s2_en;
   assign w_out_xfer = r_s2_valid & OUT_READY;

   assign IN_READY   = w_s1_en;
   assign OUT_VALID  = r_s2_valid;
   assign INSTR      = r_s2_instr;
   assign ERR        = r_s2_err;
   assign ERRCNT     = r_errcnt;

   // The value fits a signed field when all bits above the field's sign bit
   // equal that sign bit.
   assign w_fit11 = (&r_s1_imm[31:11]) | ~(|r_s1_imm[31:11]);
   assign w_fit12 = (&r_s1_imm[31:12]) | ~(|r_s1_imm[31:12]);
   assign w_fit20 = (&r_s1_imm[31:20]) | ~(|r_s1_imm[31:20]);

   // Scatter the stage-1 immediate over the template; vector bit k is INSTR[k+7].
   always_comb begin
      // NOTE: every output gets a default before the case, so no path can
      // leave one unassigned and infer a latch.
      w_instr = r_s1_tmpl;
      w_err   = 1'b0;
      case (r_s1_fmt)
         FMT_I: begin
            w_instr[24:13] = r_s1_imm[11:0];
            w_err          = ~w_fit11;
         end
         FMT_S: begin
            w_instr[24:18] = r_s1_imm[11:5];
            w_instr[4:0]   = r_s1_imm[4:0];
            w_err          = ~w_fit11;
         end
         FMT_B: begin
            w_instr[24]    = r_s1_imm[12];
            w_instr[23:18] = r_s1_imm[10:5];
            w_instr[4:1]   = r_s1_imm[4:1];
            w_instr[0]     = r_s1_imm[11];
            w_err          = ~w_fit12 | r_s1_imm[0];
         end
         FMT_J: begin
            w_instr[24]    = r_s1_imm[20];
            w_instr[23:14] = r_s1_imm[10:1];
            w_instr[13]    = r_s1_imm[11];
            w_instr[12:5]  = r_s1_imm[19:12];
            w_err          = ~w_fit20 | r_s1_imm[0];
         end
         default: begin
            // Unknown format select: make the corruption visible downstream.
            w_instr = 'x;
            w_err   = 1'bx;
         end
      endcase
   end

   // Stage 1 register: accept a new beat whenever the stage can advance.
   always_ff @(posedge CLK) begin
      // NOTE: non-blocking assignments for all state so every register
      // samples pre-edge values regardless of block ordering.
      if (RST) begin
         r_s1_valid <= 1'b0;
      end else if (w_s1_en) begin
         r_s1_valid <= IN_VALID;
         if (IN_VALID) begin
            r_s1_imm  <= IMM;
            r_s1_fmt  <= fmt_e'(IMMSCR);
            r_s1_tmpl <= TEMPLATE;
         end
      end
   end

   // Stage 2 register: capture the encoded beat; data holds while stalled.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_s2_valid <= 1'b0;
         r_s2_instr <= '0;
         r_s2_err   <= 1'b0;
      end else if (w_s2_en) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_instr <= w_instr;
            r_s2_err   <= w_err;
         end
      end
   end

   // Count flagged beats as they leave the block, holding at all-ones.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_errcnt <= '0;
      end else if (w_out_xfer && r_s2_err && !(&r_errcnt)) begin
         r_errcnt <= r_errcnt + 1'b1;
      end
   end

endmodule
